// File: rtl/interrupt_ctrl.sv
// Interrupt controller: latches and prioritises WIDTH sources and presents one at a time
// through a req/ack/eoi handshake, then pulses a clear back to the serviced source.
module interrupt_ctrl #(
  parameter int WIDTH    = 31,
  parameter int IDW      = 5,
  parameter int HOLD_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq_in,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_edge,
  output logic             irq_req,
  output logic [IDW-1:0]   irq_id,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic [WIDTH-1:0] src_clr,
  output logic [WIDTH-1:0] pending,
  output logic             in_service
);

  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SVC,
    CLR,
    HOLD
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] irq_d_reg;
  logic [WIDTH-1:0] pending_reg, pending_next;
  logic [WIDTH-1:0] src_clr_reg, src_clr_next;
  logic [IDW-1:0]   irq_id_reg, irq_id_next;
  logic             irq_req_reg, irq_req_next;
  logic             in_service_reg, in_service_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [WIDTH-1:0] candidates;
  logic [WIDTH-1:0] id_onehot;
  logic [IDW-1:0]   win_id;
  logic             accept;

  assign candidates = pending_reg & ~irq_mask;
  assign id_onehot  = {{(WIDTH-1){1'b0}}, 1'b1} << irq_id_reg;
  assign accept     = (state_reg == REQ) && irq_ack;

  // Edge sources latch until accepted (a new edge beats the clear); level sources just follow the line.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pend
      assign pending_next[gi] = irq_edge[gi]
        ? ((irq_in[gi] & ~irq_d_reg[gi]) | (pending_reg[gi] & ~(accept & id_onehot[gi])))
        : irq_in[gi];
    end
  endgenerate

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win_id = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        win_id = IDW'(i);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    irq_req_next    = irq_req_reg;
    irq_id_next     = irq_id_reg;
    in_service_next = in_service_reg;
    src_clr_next    = '0;
    cnt_next        = cnt_reg;
    case (state_reg)
      IDLE: begin
        irq_id_next = '0;
        if (|candidates) begin
          irq_id_next  = win_id;
          irq_req_next = 1'b1;
          state_next   = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          irq_req_next    = 1'b0;
          in_service_next = 1'b1;
          state_next      = SVC;
        end else if (!(|(candidates & id_onehot))) begin
          // Source masked or level dropped before acceptance: withdraw quietly.
          irq_req_next = 1'b0;
          irq_id_next  = '0;
          state_next   = IDLE;
        end
      end
      SVC: begin
        if (irq_eoi) begin
          src_clr_next = id_onehot;
          state_next   = CLR;
        end
      end
      CLR: begin
        in_service_next = 1'b0;
        cnt_next        = CW'(HOLD_CYC - 1);
        state_next      = HOLD;
      end
      HOLD: begin
        // Give a level source time to drop after its clear before arbitrating again.
        if (cnt_reg == '0) begin
          irq_id_next = '0;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      irq_d_reg      <= '0;
      pending_reg    <= '0;
      src_clr_reg    <= '0;
      irq_id_reg     <= '0;
      irq_req_reg    <= 1'b0;
      in_service_reg <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      irq_d_reg      <= irq_in;
      pending_reg    <= pending_next;
      src_clr_reg    <= src_clr_next;
      irq_id_reg     <= irq_id_next;
      irq_req_reg    <= irq_req_next;
      in_service_reg <= in_service_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign irq_req    = irq_req_reg;
  assign irq_id     = irq_id_reg;
  assign src_clr    = src_clr_reg;
  assign pending    = pending_reg;
  assign in_service = in_service_reg;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: a per-cycle vector table checked through a scoreboard queue,
// followed by a status-register loop sequence and a reset-in-service sequence.
module tb_interrupt_ctrl;

  localparam int W   = 31;
  localparam int IDW = 5;
  localparam logic [W-1:0] E1 = 31'h7FFF_FFFF;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   irq_in, irq_mask, irq_edge;
  logic           irq_req;
  logic [IDW-1:0] irq_id;
  logic           irq_ack, irq_eoi;
  logic [W-1:0]   src_clr, pending;
  logic           in_service;

  always #5 clk = ~clk;

  interrupt_ctrl #(.WIDTH(W), .IDW(IDW), .HOLD_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .irq_mask  (irq_mask),
    .irq_edge  (irq_edge),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi),
    .src_clr   (src_clr),
    .pending   (pending),
    .in_service(in_service)
  );

  typedef struct packed {
    logic           rst;
    logic [W-1:0]   in;
    logic [W-1:0]   mask;
    logic [W-1:0]   edg;
    logic           ack;
    logic           eoi;
    logic           req;
    logic [IDW-1:0] id;
    logic [W-1:0]   clr;
    logic [W-1:0]   pend;
    logic           insvc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic status;
  int   clr_cnt;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=0x%0h required=0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [W-1:0] i_in, input logic [W-1:0] i_mask,
                     input logic [W-1:0] i_edg, input logic i_ack, input logic i_eoi,
                     input logic e_req, input logic [IDW-1:0] e_id, input logic [W-1:0] e_clr,
                     input logic [W-1:0] e_pend, input logic e_insvc);
    vec_t v;
    v.rst = r;   v.in = i_in;   v.mask = i_mask; v.edg = i_edg;
    v.ack = i_ack; v.eoi = i_eoi;
    v.req = e_req; v.id = e_id; v.clr = e_clr; v.pend = e_pend; v.insvc = e_insvc;
    vecs.push_back(v);
  endtask

  // One clock with the status-register generator model on source 0.
  task automatic tick();
    @(posedge clk);
    #1;
    if (src_clr[0]) begin
      status = 1'b0;
      clr_cnt++;
    end
    irq_in[0] = status;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!irq_req && n < 10) begin
      tick();
      n++;
    end
    chk(nm, n, 32'(irq_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    int   spurious;
    rst = 1'b1; irq_in = '0; irq_mask = '0; irq_edge = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
    status = 1'b0; clr_cnt = 0;

    // rst in mask edge ack eoi | req id clr pend insvc
    // Edge mode, source 3
    add(1, 0, 0, E1, 0, 0,  0, 0, 0, 0, 0);
    add(0, 31'h8, 0, E1, 0, 0,  0, 0, 0, 31'h8, 0);
    add(0, 0, 0, E1, 0, 0,  1, 3, 0, 31'h8, 0);
    add(0, 0, 0, E1, 0, 0,  1, 3, 0, 31'h8, 0);
    add(0, 0, 0, E1, 1, 0,  0, 3, 0, 0, 1);
    add(0, 0, 0, E1, 0, 0,  0, 3, 0, 0, 1);
    add(0, 0, 0, E1, 0, 1,  0, 3, 31'h8, 0, 1);
    add(0, 0, 0, E1, 0, 0,  0, 3, 0, 0, 0);
    add(0, 0, 0, E1, 0, 0,  0, 3, 0, 0, 0);
    add(0, 0, 0, E1, 0, 0,  0, 0, 0, 0, 0);
    // Level priority: 2 before 5, 5 presented four cycles after eoi
    add(0, 31'h24, 0, 0, 0, 0,  0, 0, 0, 31'h24, 0);
    add(0, 31'h24, 0, 0, 0, 0,  1, 2, 0, 31'h24, 0);
    add(0, 31'h24, 0, 0, 1, 0,  0, 2, 0, 31'h24, 1);
    add(0, 31'h24, 0, 0, 0, 1,  0, 2, 31'h4, 31'h24, 1);
    add(0, 31'h20, 0, 0, 0, 0,  0, 2, 0, 31'h20, 0);
    add(0, 31'h20, 0, 0, 0, 0,  0, 2, 0, 31'h20, 0);
    add(0, 31'h20, 0, 0, 0, 0,  0, 0, 0, 31'h20, 0);
    add(0, 31'h20, 0, 0, 0, 0,  1, 5, 0, 31'h20, 0);
    add(0, 31'h20, 0, 0, 1, 0,  0, 5, 0, 31'h20, 1);
    add(0, 0, 0, 0, 0, 1,  0, 5, 31'h20, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 5, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 5, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // No preemption: 7 holds while 1 arrives
    add(0, 31'h80, 0, 0, 0, 0,  0, 0, 0, 31'h80, 0);
    add(0, 31'h80, 0, 0, 0, 0,  1, 7, 0, 31'h80, 0);
    add(0, 31'h82, 0, 0, 0, 0,  1, 7, 0, 31'h82, 0);
    add(0, 31'h82, 0, 0, 0, 0,  1, 7, 0, 31'h82, 0);
    add(0, 31'h82, 0, 0, 1, 0,  0, 7, 0, 31'h82, 1);
    add(0, 31'h82, 0, 0, 0, 1,  0, 7, 31'h80, 31'h82, 1);
    add(0, 31'h2, 0, 0, 0, 0,  0, 7, 0, 31'h2, 0);
    add(0, 31'h2, 0, 0, 0, 0,  0, 7, 0, 31'h2, 0);
    add(0, 31'h2, 0, 0, 0, 0,  0, 0, 0, 31'h2, 0);
    add(0, 31'h2, 0, 0, 0, 0,  1, 1, 0, 31'h2, 0);
    add(0, 31'h2, 0, 0, 1, 0,  0, 1, 0, 31'h2, 1);
    add(0, 0, 0, 0, 0, 1,  0, 1, 31'h2, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // Withdraw by mask, then ack and mask together
    add(0, 31'h10, 0, 0, 0, 0,  0, 0, 0, 31'h10, 0);
    add(0, 31'h10, 0, 0, 0, 0,  1, 4, 0, 31'h10, 0);
    add(0, 31'h10, 31'h10, 0, 0, 0,  0, 0, 0, 31'h10, 0);
    add(0, 31'h10, 31'h10, 0, 0, 0,  0, 0, 0, 31'h10, 0);
    add(0, 31'h10, 0, 0, 0, 0,  1, 4, 0, 31'h10, 0);
    add(0, 31'h10, 31'h10, 0, 1, 0,  0, 4, 0, 31'h10, 1);
    add(0, 31'h10, 31'h10, 0, 0, 1,  0, 4, 31'h10, 31'h10, 1);
    add(0, 0, 0, 0, 0, 0,  0, 4, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 4, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; irq_in = vecs[i].in; irq_mask = vecs[i].mask; irq_edge = vecs[i].edg;
      irq_ack = vecs[i].ack; irq_eoi = vecs[i].eoi;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      $display("vec %0d: req=%0b id=%0d clr=%h pend=%h insvc=%0b", i, irq_req, irq_id, src_clr, pending, in_service);
      chk("irq_req", i, 32'(irq_req), 32'(e.req));
      chk("irq_id", i, 32'(irq_id), 32'(e.id));
      chk("src_clr", i, 32'(src_clr), 32'(e.clr));
      chk("pending", i, 32'(pending), 32'(e.pend));
      chk("in_service", i, 32'(in_service), 32'(e.insvc));
    end
    irq_ack = 1'b0; irq_eoi = 1'b0; irq_mask = '0; irq_edge = '0; irq_in = '0;

    // Status-register loop on source 0: exactly one clear, no second request
    status = 1'b1; irq_in[0] = status; clr_cnt = 0;
    wait_req("loop_req");
    chk("loop_id", 0, 32'(irq_id), 32'd0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("loop_insvc", 0, 32'(in_service), 32'd1);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    spurious = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (irq_req) spurious++;
    end
    $display("loop: clears=%0d spurious=%0d status=%0b", clr_cnt, spurious, status);
    chk("loop_clr_cnt", 0, 32'(clr_cnt), 32'd1);
    chk("loop_spurious", 0, 32'(spurious), 32'd0);
    chk("loop_status", 0, 32'(status), 32'd0);
    chk("loop_pending", 0, 32'(pending), 32'd0);

    // Reset while in service: everything clears, no clear pulse
    status = 1'b1; irq_in[0] = status; clr_cnt = 0;
    wait_req("rst_req");
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("rst_pre_insvc", 0, 32'(in_service), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_req_out", 0, 32'(irq_req), 32'd0);
    chk("rst_id", 0, 32'(irq_id), 32'd0);
    chk("rst_clr", 0, 32'(src_clr), 32'd0);
    chk("rst_pending", 0, 32'(pending), 32'd0);
    chk("rst_insvc", 0, 32'(in_service), 32'd0);
    status = 1'b0; irq_in[0] = status;
    for (int k = 0; k < 8; k++) tick();
    $display("reset: clears=%0d req=%0b", clr_cnt, irq_req);
    chk("rst_no_clr", 0, 32'(clr_cnt), 32'd0);
    chk("rst_idle_req", 0, 32'(irq_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Receiving end of the peripheral interrupt lines.
- Latches and prioritises up to WIDTH interrupt sources, presents one request and ID at a time to the CPU/NVIC-side handler, and runs a request/acknowledge/end-of-interrupt handshake.
- On end-of-interrupt it returns a one-cycle clear pulse to the originating source's clear input, which closes the loop with the per-source status registers in the peripherals.

Parameters:
- WIDTH, 31: number of interrupt sources.
- IDW, 5: width of the source ID; must satisfy 2^IDW >= WIDTH.
- HOLD_CYC, 2: idle holdoff cycles after a clear pulse, so a level source's status can drop before it is resampled.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- irq_in  in  WIDTH  interrupt lines from the sources.
- irq_mask  in  WIDTH  1 = source masked (not eligible for arbitration).
- irq_edge  in  WIDTH  1 = rising-edge mode, 0 = level mode.
- irq_req  out  1  request to the handler.
- irq_id  out  IDW  ID of the requested or in-service source.
- irq_ack  in  1  handler accepts the request.
- irq_eoi  in  1  handler finished servicing.
- src_clr  out  WIDTH  one-cycle clear pulse to the serviced source.
- pending  out  WIDTH  pending vector.
- in_service  out  1  a source is between ack and eoi.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high at a clk edge, all registers clear: irq_req=0, irq_id=0, src_clr=0, pending=0, in_service=0, FSM=IDLE, edge history=0. Reset mid-handshake abandons the transaction silently; no src_clr pulse is issued.
- Edge history: irq_d <= irq_in every cycle.
- Pending, edge-mode bit i:
  - Set when irq_in[i] & ~irq_d[i].
  - Cleared on acceptance of ID i (REQ & irq_ack).
  - If set and clear occur in the same cycle, set wins.
- Pending, level-mode bit i: pending[i] <= irq_in[i] every cycle.
- Arbitration: candidates = pending & ~irq_mask. The lowest index wins. Arbitration is purely combinational on registered pending.
- FSM states: IDLE, REQ, SVC, CLR, HOLD.
- IDLE:
  - If candidates != 0, latch the winner into irq_id, set irq_req=1, go to REQ.
  - Latency: an edge on irq_in at edge N gives pending at N+1 and irq_req high after N+2.
  - irq_ack and irq_eoi are ignored in IDLE.
- REQ:
  - irq_req=1 and irq_id is held stable. There is no preemption; a higher-priority arrival waits.
  - If irq_ack: irq_req<=0, in_service<=1, go to SVC.
  - Otherwise, if candidates[irq_id]==0 (masked, or level source dropped): withdraw, irq_req<=0, irq_id<=0, go to IDLE.
  - If ack and withdraw occur in the same cycle, ack wins.
- SVC:
  - Wait for irq_eoi. irq_ack is ignored.
  - On irq_eoi: src_clr[irq_id]<=1, go to CLR.
- CLR:
  - src_clr is high for exactly this one cycle.
  - in_service<=0, counter<=HOLD_CYC-1, go to HOLD.
- HOLD:
  - Counter decrements; no arbitration takes place.
  - At 0: irq_id<=0, go to IDLE.
  - Minimum gap from eoi to the next irq_req is HOLD_CYC+2 cycles.
- src_clr is one-hot or zero, never multi-bit.
- irq_id is 0 whenever the FSM is in IDLE.
- Out-of-range IDs (>= WIDTH) are never produced.

Test Plan:
- Edge, source 3:
  - Stimulus: irq_edge=all 1, mask=0; pulse irq_in[3] for 1 cycle.
  - Required: pending[3]=1 next cycle; irq_req=1 with irq_id=3 two cycles after the pulse.
  - Then: ack clears pending[3] and raises in_service; eoi gives src_clr=0x8 for exactly 1 cycle; in_service=0.
- Priority:
  - Stimulus: level mode; irq_in[5] and irq_in[2] rise together.
  - Required: irq_id=2 first. After eoi, with source 2 dropped within the holdoff, irq_id=5 is presented HOLD_CYC+2 cycles after eoi.
- No preemption:
  - Stimulus: in REQ with irq_id=7, irq_in[1] rises.
  - Required: irq_id stays 7 until ack; 1 is requested only after the 7 handshake completes.
- Withdraw:
  - Stimulus: level source 4 requesting; set irq_mask[4]=1 before ack.
  - Required: irq_req drops next cycle, irq_id=0, no src_clr. Same cycle ack+mask → accepted (in_service=1).
- Loop with a generator model:
  - Stimulus: status bit 0 feeds irq_in[0] in level mode; handle to eoi.
  - Required: src_clr[0] clears the status; no spurious second request for 0.
  - Then: reset asserted in SVC → all outputs 0 next cycle, src_clr never pulses.
